// File: rtl/ad100_soc_if.sv
// Status and program-load bus of the ad100_soc single-cycle RV32I system.
// The loader writes one memory word per cycle when ld_we is high.
interface ad100_soc_if;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] ram0;
    logic        halted;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    modport master (
        output ld_we, ld_addr, ld_data,
        input  instruction, pc, ram0, halted
    );

    modport slave (
        input  ld_we, ld_addr, ld_data,
        output instruction, pc, ram0, halted
    );
endinterface

// File: rtl/ad100_soc.sv
// ad100_soc: single-cycle RV32I CPU (block cpu) with a unified word memory (ram).
// Define AD100_HALT_DETECT_EN to make halted latch on a self-jump.
module ad100_soc #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter string       MEM_INIT  = "prog.hex"
) (
    input  logic        clk,
    input  logic        rst_n,
    ad100_soc_if.slave  bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0] ram [MEM_WORDS];

    logic [31:0]   dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;
    logic [3:0]    dmem_wstrb;
    logic [AW-1:0] dmem_idx;
    logic          halted;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic alt);
        logic [31:0] r;
        case (op)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    generate if (1) begin : cpu
        localparam logic [6:0] OpLui    = 7'b0110111;
        localparam logic [6:0] OpAuipc  = 7'b0010111;
        localparam logic [6:0] OpJal    = 7'b1101111;
        localparam logic [6:0] OpJalr   = 7'b1100111;
        localparam logic [6:0] OpBranch = 7'b1100011;
        localparam logic [6:0] OpLoad   = 7'b0000011;
        localparam logic [6:0] OpStore  = 7'b0100011;
        localparam logic [6:0] OpImm    = 7'b0010011;
        localparam logic [6:0] OpReg    = 7'b0110011;

        logic [31:0] instruction;
        logic [31:0] pc_q, pc_d, pc_plus4;
        logic [31:0] rf_q [32];

        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  funct3;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [31:0] rs1_val, rs2_val;
        logic        rd_we;
        logic [31:0] rd_wdata;
        logic        br_taken;
        logic        self_jump;
        logic [31:0] load_shift;
        logic [15:0] load_half;
        logic [31:0] load_val;
        logic        load_ok;

        assign instruction = ram[pc_q[AW+1:2]];
        assign pc_plus4    = pc_q + 32'd4;

        assign opcode = instruction[6:0];
        assign rd     = instruction[11:7];
        assign funct3 = instruction[14:12];
        assign rs1    = instruction[19:15];
        assign rs2    = instruction[24:20];

        assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
        assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
        assign imm_u = {instruction[31:12], 12'd0};
        assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};

        assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
        assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

        assign dmem_addr  = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
        assign load_shift = dmem_rdata >> {dmem_addr[1:0], 3'b000};
        assign load_half  = dmem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        always_comb begin
            load_ok  = 1'b1;
            load_val = dmem_rdata;
            case (funct3)
                3'b000:  load_val = {{24{load_shift[7]}}, load_shift[7:0]};
                3'b001:  load_val = {{16{load_half[15]}}, load_half};
                3'b010:  load_val = dmem_rdata;
                3'b100:  load_val = {24'd0, load_shift[7:0]};
                3'b101:  load_val = {16'd0, load_half};
                default: load_ok  = 1'b0;
            endcase
        end

        always_comb begin
            case (funct3)
                3'b000:  br_taken = (rs1_val == rs2_val);
                3'b001:  br_taken = (rs1_val != rs2_val);
                3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
                3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
                3'b110:  br_taken = (rs1_val <  rs2_val);
                3'b111:  br_taken = (rs1_val >= rs2_val);
                default: br_taken = 1'b0;
            endcase
        end

        always_comb begin
            pc_d       = pc_plus4;
            rd_we      = 1'b0;
            rd_wdata   = 32'd0;
            dmem_wstrb = 4'd0;
            dmem_wdata = 32'd0;
            self_jump  = 1'b0;
            case (opcode)
                OpLui: begin
                    rd_we    = 1'b1;
                    rd_wdata = imm_u;
                end
                OpAuipc: begin
                    rd_we    = 1'b1;
                    rd_wdata = pc_q + imm_u;
                end
                OpJal: begin
                    rd_we     = 1'b1;
                    rd_wdata  = pc_plus4;
                    pc_d      = pc_q + imm_j;
                    self_jump = (imm_j == 32'd0);
                end
                OpJalr: begin
                    // Target uses rs1 sampled before the link write, so rd==rs1 works.
                    rd_we    = 1'b1;
                    rd_wdata = pc_plus4;
                    pc_d     = (rs1_val + imm_i) & ~32'd1;
                end
                OpBranch: begin
                    if (br_taken) begin
                        pc_d      = pc_q + imm_b;
                        self_jump = (imm_b == 32'd0);
                    end
                end
                OpLoad: begin
                    rd_we    = load_ok;
                    rd_wdata = load_val;
                end
                OpStore: begin
                    case (funct3)
                        3'b000: begin
                            dmem_wstrb = 4'b0001 << dmem_addr[1:0];
                            dmem_wdata = {4{rs2_val[7:0]}};
                        end
                        3'b001: begin
                            dmem_wstrb = dmem_addr[1] ? 4'b1100 : 4'b0011;
                            dmem_wdata = {2{rs2_val[15:0]}};
                        end
                        3'b010: begin
                            dmem_wstrb = 4'b1111;
                            dmem_wdata = rs2_val;
                        end
                        default: ;
                    endcase
                end
                OpImm: begin
                    rd_we    = 1'b1;
                    rd_wdata = alu(rs1_val, imm_i, funct3,
                                   (funct3 == 3'b101) && instruction[30]);
                end
                OpReg: begin
                    rd_we    = 1'b1;
                    rd_wdata = alu(rs1_val, rs2_val, funct3, instruction[30]);
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pc_q <= 32'd0;
                for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
            end else begin
                pc_q <= pc_d;
                if (rd_we && (rd != 5'd0)) rf_q[rd] <= rd_wdata;
            end
        end

`ifdef AD100_HALT_DETECT_EN
        logic halted_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                halted_q <= 1'b0;
            end else if (self_jump) begin
                halted_q <= 1'b1;
            end
        end

        assign halted = halted_q;
`else
        logic unused_self_jump;

        assign unused_self_jump = self_jump;
        assign halted           = 1'b0;
`endif
    end endgenerate

    assign dmem_idx   = dmem_addr[AW+1:2];
    assign dmem_rdata = ram[dmem_idx];

    // Loader has priority; CPU stores are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (bus.ld_we) begin
            ram[bus.ld_addr[AW-1:0]] <= bus.ld_data;
        end else if (rst_n) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wstrb[b]) ram[dmem_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
        end
    end

    logic unused_bits;

    assign unused_bits = ^{bus.ld_addr[31:AW], dmem_addr[31:AW+2]};

    assign bus.instruction = cpu.instruction;
    assign bus.pc          = cpu.pc_q;
    assign bus.ram0        = ram[0];
    assign bus.halted      = halted;
endmodule

// File: tb/tb_ad100_soc.sv
// Directed bench for ad100_soc: hand-assembled programs loaded through the bus,
// expected values queued at load time and popped as results are observed.
module tb_ad100_soc;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ad100_soc_if bus_if ();

    ad100_soc #(
        .MEM_WORDS(1024),
        .MEM_INIT ("")
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] prog[$];
    int          n_assert = 0;
    int          n_fail   = 0;

`ifdef AD100_HALT_DETECT_EN
    localparam logic [31:0] HaltExp = 32'd1;
`else
    localparam logic [31:0] HaltExp = 32'd0;
`endif

    localparam logic [6:0] OpImm = 7'b0010011;
    localparam logic [6:0] OpLd  = 7'b0000011;

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11],
                7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3,
                                          input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] idx, input logic [31:0] data);
        bus_if.ld_we   = 1'b1;
        bus_if.ld_addr = idx;
        bus_if.ld_data = data;
        @(posedge clk);
        #1;
        bus_if.ld_we   = 1'b0;
    endtask

    task automatic load_prog();
        rst_n = 1'b0;
        foreach (prog[i]) load_word(i, prog[i]);
        prog.delete();
        step(1);
    endtask

    task automatic exp_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus_if.ld_we   = 1'b0;
        bus_if.ld_addr = 32'd0;
        bus_if.ld_data = 32'd0;
        for (int i = 0; i < 1024; i++) load_word(i, 32'd0);

        // Reset state and first instruction.
        prog.push_back(enc_i(5, 0, 0, 1, OpImm));
        load_prog();
        step(1);
        exp_push("rst_pc", 32'd0);
        exp_push("rst_instr", 32'h0050_0093);
        exp_push("rst_halted", 32'd0);
        exp_push("rst_x1", 32'd0);
        exp_push("rst_x31", 32'd0);
        chk(bus_if.pc);
        chk(bus_if.instruction);
        chk({31'd0, bus_if.halted});
        chk(dut.cpu.rf_q[1]);
        chk(dut.cpu.rf_q[31]);
        rst_n = 1'b1;
        step(1);
        exp_push("addi_x1", 32'd5);
        exp_push("addi_pc", 32'd4);
        chk(dut.cpu.rf_q[1]);
        chk(bus_if.pc);

        // Store then spin on a self-jump.
        prog.push_back(enc_i(7, 0, 0, 1, OpImm));
        prog.push_back(enc_s(0, 1, 0, 2));
        prog.push_back(enc_j(0, 0));
        load_prog();
        exp_push("sw_ram0", 32'd7);
        exp_push("spin_instr", 32'h0000_006f);
        exp_push("spin_pc", 32'd8);
        exp_push("spin_halted", HaltExp);
        rst_n = 1'b1;
        step(2);
        chk(bus_if.ram0);
        step(3);
        chk(bus_if.instruction);
        chk(bus_if.pc);
        chk({31'd0, bus_if.halted});

        // Byte store into word 0 and sign/zero-extending loads.
        prog.push_back(enc_i(32'h80, 0, 0, 1, OpImm));
        prog.push_back(enc_s(1, 1, 0, 0));
        prog.push_back(enc_i(1, 0, 0, 2, OpLd));
        prog.push_back(enc_i(1, 0, 4, 3, OpLd));
        prog.push_back(enc_i(0, 0, 1, 4, OpLd));
        prog.push_back(enc_i(2, 0, 5, 5, OpLd));
        prog.push_back(enc_j(0, 0));
        load_prog();
        exp_push("sb_ram0", 32'h0800_8093);
        exp_push("lb", 32'hFFFF_FF80);
        exp_push("lbu", 32'h0000_0080);
        exp_push("lh", 32'hFFFF_8093);
        exp_push("lhu", 32'h0000_0800);
        exp_push("ld_pc", 32'd24);
        rst_n = 1'b1;
        step(8);
        chk(bus_if.ram0);
        chk(dut.cpu.rf_q[2]);
        chk(dut.cpu.rf_q[3]);
        chk(dut.cpu.rf_q[4]);
        chk(dut.cpu.rf_q[5]);
        chk(bus_if.pc);

        // Indirect calls through a pointer table; link and target share x5.
        prog.push_back(enc_i(68, 0, 0, 8, OpImm));
        prog.push_back(enc_i(0, 0, 0, 9, OpImm));
        prog.push_back(enc_i(3, 0, 0, 18, OpImm));
        prog.push_back(enc_i(0, 8, 2, 5, OpLd));
        prog.push_back(enc_i(0, 5, 0, 5, 7'b1100111));
        prog.push_back(enc_r(0, 10, 9, 0, 9));
        prog.push_back(enc_i(4, 8, 0, 8, OpImm));
        prog.push_back(enc_i(32'hFFFF_FFFF, 18, 0, 18, OpImm));
        prog.push_back(enc_b(32'hFFFF_FFEC, 0, 18, 1));
        prog.push_back(enc_s(0, 9, 0, 2));
        prog.push_back(enc_b(0, 0, 0, 0));
        for (int f = 1; f <= 3; f++) begin
            prog.push_back(enc_i(f, 0, 0, 10, OpImm));
            prog.push_back(enc_i(0, 5, 0, 0, 7'b1100111));
        end
        prog.push_back(32'd44);
        prog.push_back(32'd52);
        prog.push_back(32'd60);
        load_prog();
        exp_push("fptr_ram0", 32'd6);
        exp_push("fptr_pc", 32'd40);
        exp_push("fptr_link", 32'd20);
        exp_push("fptr_halted", HaltExp);
        rst_n = 1'b1;
        step(40);
        chk(bus_if.ram0);
        chk(bus_if.pc);
        chk(dut.cpu.rf_q[5]);
        chk({31'd0, bus_if.halted});

        // Shift, compare and x0 edge cases.
        prog.push_back(enc_u(32'h80000, 1, 7'b0110111));
        prog.push_back(enc_i(32'h41F, 1, 5, 2, OpImm));
        prog.push_back(enc_i(31, 1, 5, 3, OpImm));
        prog.push_back(enc_i(32'hFFFF_FFFF, 0, 0, 4, OpImm));
        prog.push_back(enc_r(0, 4, 0, 3, 5));
        prog.push_back(enc_r(0, 4, 0, 2, 6));
        prog.push_back(enc_i(1, 0, 0, 0, OpImm));
        prog.push_back(enc_u(1, 9, 7'b0010111));
        prog.push_back(enc_i(9, 0, 0, 10, OpImm));
        prog.push_back(enc_r(0, 0, 10, 0, 10));
        prog.push_back(enc_r(32'h20, 1, 4, 0, 11));
        prog.push_back(enc_r(32'h20, 4, 1, 5, 12));
        prog.push_back(enc_j(0, 0));
        load_prog();
        exp_push("srai31", 32'hFFFF_FFFF);
        exp_push("srli31", 32'd1);
        exp_push("sltu", 32'd1);
        exp_push("slt", 32'd0);
        exp_push("x0_kept", 32'd0);
        exp_push("auipc", 32'h0000_101C);
        exp_push("x0_read", 32'd9);
        exp_push("sub", 32'h7FFF_FFFF);
        exp_push("sra_low5", 32'hFFFF_FFFF);
        exp_push("arith_pc", 32'd48);
        rst_n = 1'b1;
        step(16);
        chk(dut.cpu.rf_q[2]);
        chk(dut.cpu.rf_q[3]);
        chk(dut.cpu.rf_q[5]);
        chk(dut.cpu.rf_q[6]);
        chk(dut.cpu.rf_q[0]);
        chk(dut.cpu.rf_q[9]);
        chk(dut.cpu.rf_q[10]);
        chk(dut.cpu.rf_q[11]);
        chk(dut.cpu.rf_q[12]);
        chk(bus_if.pc);

        // One-cycle reset mid-run keeps memory and restarts at 0.
        prog.push_back(enc_i(32'h55, 0, 0, 1, OpImm));
        prog.push_back(enc_s(128, 1, 0, 2));
        prog.push_back(enc_i(1, 2, 0, 2, OpImm));
        prog.push_back(enc_j(32'hFFFF_FFFC, 0));
        load_prog();
        exp_push("pre_rst_x2", 32'd2);
        exp_push("mid_rst_pc", 32'd0);
        exp_push("mid_rst_x2", 32'd0);
        exp_push("mid_rst_ram", 32'h0000_0055);
        exp_push("mid_rst_halted", 32'd0);
        exp_push("restart_pc", 32'd4);
        exp_push("restart_x1", 32'h0000_0055);
        rst_n = 1'b1;
        step(6);
        chk(dut.cpu.rf_q[2]);
        rst_n = 1'b0;
        step(1);
        chk(bus_if.pc);
        chk(dut.cpu.rf_q[2]);
        chk(dut.ram[32]);
        chk({31'd0, bus_if.halted});
        rst_n = 1'b1;
        step(1);
        chk(bus_if.pc);
        chk(dut.cpu.rf_q[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
